lu_seq_controller: RTL and testbench

LU_SEQ_CONTROLLER -- requirements
Module: lu_seq_controller

---
 rtl/lu_seq_controller.sv | 123 ++++++++++++
 tb/tb_lu_seq_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_seq_controller.sv
// Sequencing controller for an external AND/OR logic unit: collects two operands from a shared
// bus, lets the unit evaluate for one cycle, then holds the captured result until acknowledged.
module lu_seq_controller #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_op,
    input  logic [W-1:0] i_data_in,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    output logic [W-1:0] o_data_a,
    output logic [W-1:0] o_data_b,
    output logic         o_control,
    input  logic [W-1:0] i_lu_out,
    input  logic         i_lu_n,
    input  logic         i_lu_z,
    output logic [W-1:0] o_result,
    output logic         o_flag_n,
    output logic         o_flag_z,
    output logic         o_done,
    input  logic         i_ack,
    output logic         o_busy,
    output logic [7:0]   o_op_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StGetA,
        StGetB,
        StExec,
        StHold
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_data_a;
    logic [W-1:0] r_data_b;
    logic         r_control;
    logic [W-1:0] r_result;
    logic         r_flag_n;
    logic         r_flag_z;
    logic         r_done;
    logic         r_busy;
    logic         r_in_ready;
    logic [7:0]   r_op_cnt;

    // Status outputs are registered alongside the state they decode, so they change on the
    // same edge as the state transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_control  <= 1'b0;
            r_result   <= '0;
            r_flag_n   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_op_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state    <= StGetA;
                        r_control  <= i_op;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                StGetA: begin
                    if (i_in_valid) begin
                        r_data_a <= i_data_in;
                        r_state  <= StGetB;
                    end
                end
                StGetB: begin
                    if (i_in_valid) begin
                        r_data_b   <= i_data_in;
                        r_state    <= StExec;
                        r_in_ready <= 1'b0;
                    end
                end
                StExec: begin
                    r_result <= i_lu_out;
                    r_flag_n <= i_lu_n;
                    r_flag_z <= i_lu_z;
                    r_op_cnt <= r_op_cnt + 8'd1;
                    r_done   <= 1'b1;
                    r_state  <= StHold;
                end
                StHold: begin
                    // A START arriving with ACK is dropped; a new operation needs IDLE first.
                    if (i_ack) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_control  = r_control;
    assign o_result   = r_result;
    assign o_flag_n   = r_flag_n;
    assign o_flag_z   = r_flag_z;
    assign o_done     = r_done;
    assign o_busy     = r_busy;
    assign o_op_cnt   = r_op_cnt;

endmodule

// File: tb/tb_lu_seq_controller.sv
// Bench for lu_seq_controller: vector table plus hand sequences, with a behavioural logic unit
// and a scoreboard of expected results popped whenever DONE is observed.
module tb_lu_seq_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [3:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_a;
    logic [3:0] data_b;
    logic       control;
    logic [3:0] lu_out;
    logic       lu_n;
    logic       lu_z;
    logic [3:0] result;
    logic       flag_n;
    logic       flag_z;
    logic       done;
    logic       ack;
    logic       busy;
    logic [7:0] op_cnt;

    lu_seq_controller #(.W(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_op       (op),
        .i_data_in  (data_in),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_data_a   (data_a),
        .o_data_b   (data_b),
        .o_control  (control),
        .i_lu_out   (lu_out),
        .i_lu_n     (lu_n),
        .i_lu_z     (lu_z),
        .o_result   (result),
        .o_flag_n   (flag_n),
        .o_flag_z   (flag_z),
        .o_done     (done),
        .i_ack      (ack),
        .o_busy     (busy),
        .o_op_cnt   (op_cnt)
    );

    // External logic unit.
    assign lu_out = control ? (data_a | data_b) : (data_a & data_b);
    assign lu_n   = lu_out[3];
    assign lu_z   = (lu_out == 4'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] res;
        logic       n;
        logic       z;
        logic [7:0] cnt;
    } sb_t;

    typedef struct {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       n;
        logic       z;
    } vec_t;

    sb_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt  = 8'd0;
    logic [3:0] last_a   = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        last_a  = 4'd0;
        exp_q.delete();
    endtask

    // One full transaction; hold_cyc > 0 also pulses START during HOLD and with the ACK.
    task automatic do_op(input logic o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] r, input logic n, input logic z,
                         input int a_wait, input int hold_cyc);
        sb_t e;
        int  cyc;
        exp_cnt = exp_cnt + 8'd1;
        e = '{res: r, n: n, z: z, cnt: exp_cnt};
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        cyc   = 0;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        op    = ~o;
        chk("in_ready_get_a", {31'd0, in_ready}, 32'd1);
        chk("busy_get_a", {31'd0, busy}, 32'd1);
        for (int i = 0; i < a_wait; i++) begin
            in_valid = 1'b0;
            data_in  = 4'($urandom);
            @(negedge clk);
            cyc++;
            chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
            chk("data_a_hold", {28'd0, data_a}, {28'd0, last_a});
        end
        in_valid = 1'b1;
        data_in  = a;
        @(negedge clk);
        cyc++;
        last_a = a;
        chk("data_a", {28'd0, data_a}, {28'd0, a});
        chk("in_ready_get_b", {31'd0, in_ready}, 32'd1);
        data_in = b;
        @(negedge clk);
        cyc++;
        in_valid = 1'b0;
        chk("data_b", {28'd0, data_b}, {28'd0, b});
        chk("in_ready_exec", {31'd0, in_ready}, 32'd0);
        chk("control", {31'd0, control}, {31'd0, o});
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", cyc, 4 + a_wait);
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("result", {28'd0, result}, {28'd0, e.res});
            chk("flag_n", {31'd0, flag_n}, {31'd0, e.n});
            chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
            chk("op_cnt", {24'd0, op_cnt}, {24'd0, e.cnt});
        end
        for (int i = 0; i < hold_cyc; i++) begin
            start = ~start;
            @(negedge clk);
            chk("hold_done", {31'd0, done}, 32'd1);
            chk("hold_result", {28'd0, result}, {28'd0, r});
            chk("hold_busy", {31'd0, busy}, 32'd1);
        end
        ack   = 1'b1;
        start = (hold_cyc > 0);
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        chk("done_after_ack", {31'd0, done}, 32'd0);
        chk("busy_after_ack", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("idle_stays", {30'd0, busy, in_ready}, 32'd0);
        chk("result_kept_idle", {28'd0, result}, {28'd0, r});
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{op: 1'b0, a: 4'b1100, b: 4'b1010, res: 4'b1000, n: 1'b1, z: 1'b0};
        vecs[1] = '{op: 1'b1, a: 4'b0000, b: 4'b0000, res: 4'b0000, n: 1'b0, z: 1'b1};
        vecs[2] = '{op: 1'b0, a: 4'b0101, b: 4'b1010, res: 4'b0000, n: 1'b0, z: 1'b1};
        vecs[3] = '{op: 1'b1, a: 4'b1100, b: 4'b0011, res: 4'b1111, n: 1'b1, z: 1'b0};
        vecs[4] = '{op: 1'b0, a: 4'b0111, b: 4'b0011, res: 4'b0011, n: 1'b0, z: 1'b0};
        vecs[5] = '{op: 1'b1, a: 4'b0001, b: 4'b0100, res: 4'b0101, n: 1'b0, z: 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        data_in  = 4'd0;
        in_valid = 1'b0;
        ack      = 1'b0;
        #3;
        chk("reset_outputs",
            {6'd0, data_a, data_b, control, result, flag_n, flag_z, done, op_cnt, busy, in_ready},
            32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].n, vecs[i].z, 0, 0);
        end

        // Stalled operand A: three idle cycles in GET_A.
        do_op(1'b1, 4'b1000, 4'b0010, 4'b1010, 1'b1, 1'b0, 3, 0);

        // DONE held through five un-acked cycles with START pulses, then ACK+START together.
        do_op(1'b0, 4'b1110, 4'b0111, 4'b0110, 1'b0, 1'b0, 0, 5);

        // Asynchronous reset while waiting in GET_B.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        data_in  = 4'hf;
        @(negedge clk);
        in_valid = 1'b0;
        chk("get_b_reached", {30'd0, busy, in_ready}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {6'd0, data_a, data_b, control, result, flag_n, flag_z, done, op_cnt, busy, in_ready},
            32'd0);
        exp_cnt = 8'd0;
        last_a  = 4'd0;
        exp_q.delete();
        @(negedge clk);

        // Reset release with START already high: the first rising edge must start.
        rst_n = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_after_release", {30'd0, busy, in_ready}, 32'd3);
        in_valid = 1'b1;
        data_in  = 4'b1111;
        @(negedge clk);
        data_in = 4'b0101;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("release_op_done", {31'd0, done}, 32'd1);
        chk("release_op_result", {27'd0, result, flag_z}, {27'd0, 4'b0101, 1'b0});
        chk("release_op_cnt", {24'd0, op_cnt}, 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Counter wrap: 256 operations from reset land on zero, the next one on one.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            logic       o;
            logic [3:0] a;
            logic [3:0] b;
            logic [3:0] r;
            o = 1'($urandom);
            a = 4'($urandom);
            b = 4'($urandom);
            r = o ? (a | b) : (a & b);
            do_op(o, a, b, r, r[3], (r == 4'd0), 0, 0);
            if (i == 255) chk("op_cnt_wrap_256", {24'd0, op_cnt}, 32'd0);
        end
        chk("op_cnt_after_257", {24'd0, op_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
